// File: rtl/ldm_stm_seq_if.sv
// ldm_stm_seq_if: memory request/acknowledge bus between the sequencer and memory
interface ldm_stm_seq_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    modport master(output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
    modport slave(input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/ldm_stm_seq.sv
// ldm_stm_seq: LDM/STM block-transfer sequencer with base-register writeback
module ldm_stm_seq (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          is_load,
    input  logic          up,
    input  logic          pre,
    input  logic          wback,
    input  logic [3:0]    rn,
    input  logic [15:0]   reglist,
    input  logic [31:0]   base,
    output logic [3:0]    rf_ra,
    input  logic [31:0]   rf_rd,
    output logic          rf_we,
    output logic [3:0]    rf_wa,
    output logic [31:0]   rf_wd,
    output logic          pc_we,
    ldm_stm_seq_if.master bus,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;
    state_t state, state_nx;
    logic ld_q, up_q, wb_q, hit_q;
    logic [3:0] rn_q, idx;
    logic [15:0] list_q, list_nx;
    logic [31:0] base_q, addr_q, n4_in, n4_q, start_addr;
    logic [4:0] n_in, n_q;
    logic last;
    always_comb begin
        n_in = '0;
        for (int i = 0; i < 16; i++) n_in = n_in + 5'(reglist[i]);
        n4_in = {25'd0, n_in, 2'b00};
        n4_q = {25'd0, n_q, 2'b00};
        start_addr = up ? (pre ? base + 32'd4 : base) : (pre ? base - n4_in : base - n4_in + 32'd4);
        idx = '0;
        for (int i = 15; i >= 0; i--) if (list_q[i]) idx = 4'(i);
        list_nx = list_q & (list_q - 16'd1);
        last = list_nx == '0;
    end
    always_comb begin
        state_nx = state;
        rf_ra = '0;
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        pc_we = 1'b0;
        bus.mem_req = 1'b0;
        bus.mem_we = 1'b0;
        bus.mem_addr = '0;
        bus.mem_wdata = '0;
        done = 1'b0;
        case (state)
            IDLE: state_nx = start ? (n_in != 0 ? XFER : DONE) : IDLE;
            XFER: begin
                bus.mem_req = 1'b1;
                bus.mem_we = !ld_q;
                bus.mem_addr = addr_q;
                bus.mem_wdata = rf_rd;
                rf_ra = idx;
                if (bus.mem_ack) begin
                    rf_we = ld_q && idx != 4'd15;
                    pc_we = ld_q && idx == 4'd15;
                    rf_wa = ld_q ? idx : 4'd0;
                    rf_wd = ld_q ? bus.mem_rdata : 32'd0;
                    // a loaded base register wins over the writeback value
                    if (last) state_nx = (wb_q && !(ld_q && hit_q)) ? WB : DONE;
                end
            end
            WB: begin
                rf_we = 1'b1;
                rf_wa = rn_q;
                rf_wd = up_q ? base_q + n4_q : base_q - n4_q;
                state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ld_q <= 1'b0;
            up_q <= 1'b0;
            wb_q <= 1'b0;
            hit_q <= 1'b0;
            rn_q <= '0;
            list_q <= '0;
            base_q <= '0;
            addr_q <= '0;
            n_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                ld_q <= is_load;
                up_q <= up;
                wb_q <= wback;
                hit_q <= reglist[rn];
                rn_q <= rn;
                list_q <= reglist;
                base_q <= base;
                addr_q <= start_addr;
                n_q <= n_in;
            end else if (state == XFER && bus.mem_ack) begin
                list_q <= list_nx;
                addr_q <= addr_q + 32'd4;
            end
        end
    end
endmodule

// File: doc/ldm_stm_seq.md
LDM_STM_SEQ -- requirements
Module: ldm_stm_seq

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  in  1  single clock; all state changes on posedge clk.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle request to begin a block transfer; sampled only in IDLE.
REQ-005 is_load  in  1  1 = LDM (memory to registers), 0 = STM (registers to memory).
REQ-006 up  in  1  U bit: 1 = increment, 0 = decrement.
REQ-007 pre  in  1  P bit: 1 = before, 0 = after.
REQ-008 wback  in  1  W bit: write the final base address back to rn.
REQ-009 rn  in  4  base register index.
REQ-010 reglist  in  16  register list; bit i selects Ri.
REQ-011 base  in  32  base address value, sampled with start.
REQ-012 rf_ra  out  4  register-file read address for store data.
REQ-013 rf_rd  in  32  register-file read data, combinational from rf_ra.
REQ-014 rf_we / rf_wa / rf_wd  out  1/4/32  register-file write port.
REQ-015 pc_we  out  1  load into R15; data is on rf_wd.
REQ-016 mem_req / mem_we / mem_addr / mem_wdata  out  1/1/32/32  memory request.
REQ-017 mem_rdata / mem_ack  in  32/1  memory read data and acknowledge, valid in the same cycle.
REQ-018 busy / done  out  1/1  busy is high whenever state != IDLE; done is a 1-cycle completion pulse.

Function
REQ-019 States SHALL be IDLE, XFER, WB and DONE.
REQ-020 In IDLE, start=1 SHALL capture is_load, up, pre, wback, rn, reglist, base and n = popcount(reglist) (0..16).
REQ-021 On start, the next state SHALL be XFER if n>0, otherwise DONE.
REQ-022 The start address SHALL be: IA = base; IB = base+4; DA = base-4n+4; DB = base-4n, all computed modulo 2^32.
REQ-023 Registers SHALL be transferred lowest index first, at ascending word addresses starting at the start address.
REQ-024 In XFER, mem_req SHALL be 1 and mem_addr SHALL equal the current address.
REQ-025 In XFER, mem_we SHALL equal !is_load and rf_ra SHALL equal the current register index.
REQ-026 In XFER, mem_wdata SHALL equal rf_rd.
REQ-027 mem_req, mem_addr, mem_we and mem_wdata SHALL remain stable until mem_ack=1.
REQ-028 On an mem_ack cycle during a load, rf_we=1, rf_wa=current index and rf_wd=mem_rdata SHALL be driven in the same cycle.
REQ-029 If the current index during a load is 15, pc_we=1 SHALL be driven instead of rf_we.
REQ-030 On an mem_ack cycle, the block SHALL advance to the next set bit and add 4 to the address.
REQ-031 After the last mem_ack, the next state SHALL be WB if wback=1 and not (is_load and reglist[rn]); otherwise DONE.
REQ-032 In WB, for one cycle: rf_we=1, rf_wa=rn, rf_wd = up ? base+4n : base-4n.
REQ-033 WB SHALL be skipped entirely when n=0.
REQ-034 In DONE, done=1 for one cycle; the next state SHALL be IDLE.
REQ-035 start SHALL be ignored while busy=1.
REQ-036 mem_ack SHALL be ignored outside XFER.
REQ-037 All outputs not driven by an active state SHALL be 0, including rf_ra in IDLE.

Reset
REQ-038 reset_n=0 SHALL immediately force IDLE and zero all registered state and all outputs, including mid-XFER with a request outstanding.
REQ-039 After reset_n is released, the first valid start SHALL operate normally.

Verification
REQ-040 STMIA: rn=13, base=0x100, reglist=0x0005, wback=1, mem_ack tied 1 -> R0 written to 0x100, R2 written to 0x104, then WB with R13=0x108, then a single done pulse.
REQ-041 LDMDB: base=0x200, reglist=0x8003, wback=0 -> reads at 0x1F4, 0x1F8 and 0x1FC; rf_we for R0 and R1; pc_we on the third word; no WB.
REQ-042 reglist=0x0000, wback=1 -> done asserted the cycle after start; no mem_req and no rf_we at any point.
REQ-043 mem_ack delayed 3 cycles per beat -> mem_req, mem_addr and mem_wdata held constant across the wait; total busy cycles = 4n+1.
REQ-044 LDMIA: rn=1, reglist=0x0006, wback=1, mem_rdata=0xAA -> R1=0xAA from the load; no WB cycle.
REQ-045 reset_n pulsed low during the second beat of a 4-register STM -> all outputs 0 immediately; a new start completes correctly.
